// File: rtl/mpe_pkg.sv
// -----------------------------------------------------------------------------
// mpe_pkg
// Shared definitions for the matrix-PE dispatch block: SRAM address width,
// beat width, uop width and the dispatcher FSM state encoding.
// -----------------------------------------------------------------------------
package mpe_pkg;

  localparam int ADDR_W = 10;   // SRAM word address width
  localparam int DATA_W = 512;  // one neuron word / one weight word
  localparam int UOP_W  = 8;    // uop carries the per-output beat count

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UOP      = 2'd1,
    ST_STREAM   = 2'd2,
    ST_WAIT_RES = 2'd3
  } mpe_state_e;

endpackage

// File: rtl/mpe_beat_fifo.sv
// -----------------------------------------------------------------------------
// mpe_beat_fifo
// Two-entry FIFO holding {neuron, weight} beat pairs between the SRAM read
// return and the PE beat interface. The head entry is presented
// combinationally so a beat can be offered in the cycle after it is pushed.
// A push into a full FIFO is accepted only together with a pop.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears occupancy)
//   push, wr_data  write strobe / pair written
//   pop           remove head entry
//   rd_data       head entry
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module mpe_beat_fifo
  import mpe_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage has no reset: an entry is only observable once count covers it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = rd_ptr_reg ? g_slot[1].entry_reg : g_slot[0].entry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mpe_dispatch.sv
// -----------------------------------------------------------------------------
// mpe_dispatch
// Command-driven feeder for the matrix PE. Accepts one job (neuron base,
// weight base, beats per output, outputs per job), and for every output:
// issues a uop carrying the beat count, streams neuron/weight beat pairs read
// from NRAM/WRAM (1-cycle read latency) through a 2-entry beat FIFO, then
// waits for the PE result and returns it tagged with the output index.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              job handshake
//   cmd_n_addr, cmd_w_addr           neuron / weight base address
//   cmd_len, cmd_rep                 beats per output, outputs per job
//   nram_rd_en/addr/data             NRAM read port (data valid next cycle)
//   wram_rd_en/addr/data             WRAM read port (data valid next cycle)
//   mpe_uop/_valid/_ready            uop to the PE
//   mpe_neuron/_valid/_ready         neuron beat to the PE
//   mpe_weight/_valid/_ready         weight beat to the PE
//   mpe_result, mpe_vld              PE result
//   res_data, res_idx, res_valid     result returned to the front end
//   done                             one-cycle pulse at job end
//   perf_busy, perf_stall            performance counters
//
// Build option: define MPE_DISPATCH_PERF_EN to include the performance
// counters; otherwise perf_busy/perf_stall are constant zero.
// -----------------------------------------------------------------------------
module mpe_dispatch
  import mpe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_n_addr,
  input  logic [ADDR_W-1:0] cmd_w_addr,
  input  logic [UOP_W-1:0]  cmd_len,
  input  logic [7:0]        cmd_rep,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_rd_addr,
  input  logic [DATA_W-1:0] nram_rd_data,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_rd_addr,
  input  logic [DATA_W-1:0] wram_rd_data,
  output logic [UOP_W-1:0]  mpe_uop,
  output logic              mpe_uop_valid,
  input  logic              mpe_uop_ready,
  output logic [DATA_W-1:0] mpe_neuron,
  output logic              mpe_neuron_valid,
  input  logic              mpe_neuron_ready,
  output logic [DATA_W-1:0] mpe_weight,
  output logic              mpe_weight_valid,
  input  logic              mpe_weight_ready,
  input  logic [31:0]       mpe_result,
  input  logic              mpe_vld,
  output logic [31:0]       res_data,
  output logic [7:0]        res_idx,
  output logic              res_valid,
  output logic              done,
  output logic [31:0]       perf_busy,
  output logic [31:0]       perf_stall
);

  mpe_state_e state_reg, state_next;

  logic [UOP_W-1:0]  len_reg;
  logic [7:0]        rep_reg;
  logic [7:0]        r_reg;
  logic [ADDR_W-1:0] n_base_reg;
  logic [ADDR_W-1:0] n_ptr_reg;
  logic [ADDR_W-1:0] w_ptr_reg;     // runs across reps: w_base + r*len + i
  logic [UOP_W-1:0]  issued_reg;
  logic [UOP_W-1:0]  accepted_reg;
  logic              rd_pend_reg;   // a read issued last cycle returns now
  logic [31:0]       res_data_reg;
  logic [7:0]        res_idx_reg;
  logic              res_valid_reg;
  logic              done_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic [2*DATA_W-1:0] fifo_head;
  logic [1:0]          occ;
  logic [2:0]          credit;
  logic                beat_valid;
  logic                beat_accept;
  logic                rd_issue;
  logic                cmd_fire;
  logic                job_empty;
  logic                last_beat;
  logic                res_fire;
  logic                last_rep;

  // ---------------------------------------------------------------------------
  // Beat FIFO and read credit
  // ---------------------------------------------------------------------------
  mpe_beat_fifo #(
    .WIDTH (2 * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rd_pend_reg),
    .wr_data ({nram_rd_data, wram_rd_data}),
    .pop     (beat_accept),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign beat_valid  = !fifo_empty;
  // A one-sided ready never consumes a beat.
  assign beat_accept = beat_valid && mpe_neuron_ready && mpe_weight_ready;

  assign occ = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // Entries owed to the FIFO after this cycle's pop; counting the pop keeps
  // one beat per cycle when the PE is always ready, and the FIFO can never
  // overflow because occupancy plus in-flight stays at most 2.
  assign credit = {1'b0, occ} + {2'b00, rd_pend_reg} - {2'b00, beat_accept};

  assign rd_issue = (state_reg == ST_STREAM) && (issued_reg != len_reg) &&
                    (credit < 3'd2);

  assign nram_rd_en   = rd_issue;
  assign wram_rd_en   = rd_issue;
  assign nram_rd_addr = n_ptr_reg;
  assign wram_rd_addr = w_ptr_reg;

  assign mpe_neuron       = fifo_head[2*DATA_W-1:DATA_W];
  assign mpe_weight       = fifo_head[DATA_W-1:0];
  assign mpe_neuron_valid = beat_valid;
  assign mpe_weight_valid = beat_valid;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign cmd_fire  = (state_reg == ST_IDLE) && cmd_valid;
  assign job_empty = (cmd_len == '0) || (cmd_rep == 8'd0);
  assign last_beat = beat_accept && (accepted_reg == len_reg - 8'd1);
  assign res_fire  = (state_reg == ST_WAIT_RES) && mpe_vld;
  assign last_rep  = (r_reg == rep_reg - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_ready     = 1'b0;
    mpe_uop_valid = 1'b0;
    mpe_uop       = '0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !job_empty) begin
          state_next = ST_UOP;
        end
      end
      ST_UOP: begin
        mpe_uop_valid = 1'b1;
        mpe_uop       = len_reg;
        if (mpe_uop_ready) begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_beat) begin
          state_next = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (mpe_vld) begin
          state_next = last_rep ? ST_IDLE : ST_UOP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg       <= '0;
      rep_reg       <= 8'd0;
      r_reg         <= 8'd0;
      n_base_reg    <= '0;
      n_ptr_reg     <= '0;
      w_ptr_reg     <= '0;
      issued_reg    <= '0;
      accepted_reg  <= '0;
      rd_pend_reg   <= 1'b0;
      res_data_reg  <= 32'd0;
      res_idx_reg   <= 8'd0;
      res_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      rd_pend_reg   <= rd_issue;

      if (cmd_fire) begin
        len_reg      <= cmd_len;
        rep_reg      <= cmd_rep;
        r_reg        <= 8'd0;
        n_base_reg   <= cmd_n_addr;
        n_ptr_reg    <= cmd_n_addr;
        w_ptr_reg    <= cmd_w_addr;
        issued_reg   <= '0;
        accepted_reg <= '0;
        // Degenerate job: acknowledge with done and generate no traffic.
        if (job_empty) begin
          done_reg <= 1'b1;
        end
      end

      if (rd_issue) begin
        n_ptr_reg  <= n_ptr_reg + 1'b1;
        w_ptr_reg  <= w_ptr_reg + 1'b1;
        issued_reg <= issued_reg + 1'b1;
      end

      if (beat_accept) begin
        accepted_reg <= accepted_reg + 1'b1;
      end

      if (res_fire) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= mpe_result;
        res_idx_reg   <= r_reg;
        if (last_rep) begin
          done_reg <= 1'b1;
        end else begin
          // Next output reuses the neuron vector; weights keep advancing.
          r_reg        <= r_reg + 8'd1;
          n_ptr_reg    <= n_base_reg;
          issued_reg   <= '0;
          accepted_reg <= '0;
        end
      end
    end
  end

  assign res_data  = res_data_reg;
  assign res_idx   = res_idx_reg;
  assign res_valid = res_valid_reg;
  assign done      = done_reg;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef MPE_DISPATCH_PERF_EN
  logic [31:0] perf_busy_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_reg  <= 32'd0;
      perf_stall_reg <= 32'd0;
    end else if (cmd_fire) begin
      perf_busy_reg  <= 32'd0;
      perf_stall_reg <= 32'd0;
    end else begin
      if ((state_reg != ST_IDLE) && (perf_busy_reg != 32'hFFFF_FFFF)) begin
        perf_busy_reg <= perf_busy_reg + 32'd1;
      end
      if ((state_reg == ST_STREAM) && beat_valid && !beat_accept &&
          (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_busy  = perf_busy_reg;
  assign perf_stall = perf_stall_reg;
`else
  assign perf_busy  = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mpe_dispatch.sv
// -----------------------------------------------------------------------------
// tb_mpe_dispatch
// Directed bench for mpe_dispatch. A job-level model (expected address lists,
// beat contents, uops and result indices derived from the job fields) is
// checked by one compare process sampling on the falling edge; directed
// literal checks pin the model for each scenario.
// -----------------------------------------------------------------------------
module tb_mpe_dispatch;
  import mpe_pkg::*;

  localparam int DW = DATA_W;
  localparam int AW = ADDR_W;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_n_addr;
  logic [AW-1:0] cmd_w_addr;
  logic [7:0]    cmd_len;
  logic [7:0]    cmd_rep;
  logic          nram_rd_en;
  logic [AW-1:0] nram_rd_addr;
  logic [DW-1:0] nram_rd_data;
  logic          wram_rd_en;
  logic [AW-1:0] wram_rd_addr;
  logic [DW-1:0] wram_rd_data;
  logic [7:0]    mpe_uop;
  logic          mpe_uop_valid;
  logic          mpe_uop_ready;
  logic [DW-1:0] mpe_neuron;
  logic          mpe_neuron_valid;
  logic          mpe_neuron_ready;
  logic [DW-1:0] mpe_weight;
  logic          mpe_weight_valid;
  logic          mpe_weight_ready;
  logic [31:0]   mpe_result;
  logic          mpe_vld;
  logic [31:0]   res_data;
  logic [7:0]    res_idx;
  logic          res_valid;
  logic          done;
  logic [31:0]   perf_busy;
  logic [31:0]   perf_stall;

  mpe_dispatch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_n_addr       (cmd_n_addr),
    .cmd_w_addr       (cmd_w_addr),
    .cmd_len          (cmd_len),
    .cmd_rep          (cmd_rep),
    .nram_rd_en       (nram_rd_en),
    .nram_rd_addr     (nram_rd_addr),
    .nram_rd_data     (nram_rd_data),
    .wram_rd_en       (wram_rd_en),
    .wram_rd_addr     (wram_rd_addr),
    .wram_rd_data     (wram_rd_data),
    .mpe_uop          (mpe_uop),
    .mpe_uop_valid    (mpe_uop_valid),
    .mpe_uop_ready    (mpe_uop_ready),
    .mpe_neuron       (mpe_neuron),
    .mpe_neuron_valid (mpe_neuron_valid),
    .mpe_neuron_ready (mpe_neuron_ready),
    .mpe_weight       (mpe_weight),
    .mpe_weight_valid (mpe_weight_valid),
    .mpe_weight_ready (mpe_weight_ready),
    .mpe_result       (mpe_result),
    .mpe_vld          (mpe_vld),
    .res_data         (res_data),
    .res_idx          (res_idx),
    .res_valid        (res_valid),
    .done             (done),
    .perf_busy        (perf_busy),
    .perf_stall       (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // SRAM contents are a pure function of address.
  function automatic logic [DW-1:0] nword(input int a);
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = 32'h4E00_0000 ^ (32'(k) << 16) ^ 32'(a);
    return v;
  endfunction

  function automatic logic [DW-1:0] wword(input int a);
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = 32'h5700_0000 ^ (32'(k) << 16) ^ 32'(a);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Model state and logs
  // ---------------------------------------------------------------------------
  int          exp_n_q[$], exp_w_q[$];       // read addresses, in order
  int          exp_bn_q[$], exp_bw_q[$];     // beat addresses, in order
  int          exp_uop_q[$], exp_idx_q[$];
  logic [31:0] exp_rdata_q[$];
  int          job_rep = 0;
  bit          zero_due = 0;
  bit          prev_stall = 0;
  bit          prev_uop_hs = 0;
  logic [DW-1:0] prev_n, prev_w;

  int n_log[$], w_log[$], acc_log[$], idx_log[$];
  int uop_cnt = 0, rd_cnt = 0, hs_cyc = 0, done_cyc = 0;

  // PE responder state
  int rsp_pend = 0, rsp_delay = 0, res_seq = 0;
  bit rsp_outstanding = 0, spur_req = 0, bp_mode = 0;

  // ---------------------------------------------------------------------------
  // SRAM model: rd_en sampled mid-cycle, data presented during the next cycle
  // ---------------------------------------------------------------------------
  initial begin
    bit n_en, w_en;
    int n_a, w_a;
    nram_rd_data = '0;
    wram_rd_data = '0;
    forever begin
      @(negedge clk);
      n_en = nram_rd_en; n_a = int'(nram_rd_addr);
      w_en = wram_rd_en; w_a = int'(wram_rd_addr);
      @(posedge clk);
      #1;
      nram_rd_data = n_en ? nword(n_a) : {(DW/32){32'hBAD0_BAD0}};
      wram_rd_data = w_en ? wword(w_a) : {(DW/32){32'hBAD1_BAD1}};
    end
  end

  // Ready driver
  initial begin
    mpe_uop_ready = 1'b1; mpe_neuron_ready = 1'b1; mpe_weight_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        mpe_uop_ready    = 1'($urandom_range(0, 1));
        mpe_neuron_ready = 1'($urandom_range(0, 1));
        mpe_weight_ready = 1'($urandom_range(0, 1));
      end else begin
        mpe_uop_ready = 1'b1; mpe_neuron_ready = 1'b1; mpe_weight_ready = 1'b1;
      end
    end
  end

  // PE result responder: result a few cycles after the last beat of a uop,
  // plus an optional stray pulse while beats are still streaming.
  initial begin
    mpe_vld = 1'b0; mpe_result = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mpe_vld = 1'b0;
      if (spur_req && rsp_pend > 0) begin
        mpe_vld = 1'b1; mpe_result = 32'hDEAD_BEEF; spur_req = 0;
      end else if (rsp_delay > 0) begin
        rsp_delay--;
        if (rsp_delay == 0) begin
          mpe_vld = 1'b1;
          mpe_result = 32'hC0DE_0000 + 32'(res_seq);
          exp_rdata_q.push_back(mpe_result);
          res_seq++;
          rsp_outstanding = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  initial begin
    bit exp_done, acc;
    int a, ei;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      exp_done = zero_due;
      zero_due = 0;

      if (cmd_valid && cmd_ready) begin
        hs_cyc = cyc;
        if (cmd_len == 0 || cmd_rep == 0) begin
          zero_due = 1;
        end else begin
          job_rep = int'(cmd_rep);
          for (int r = 0; r < int'(cmd_rep); r++) begin
            exp_uop_q.push_back(int'(cmd_len));
            exp_idx_q.push_back(r);
            for (int i = 0; i < int'(cmd_len); i++) begin
              exp_n_q.push_back((int'(cmd_n_addr) + i) % 1024);
              exp_w_q.push_back((int'(cmd_w_addr) + r * int'(cmd_len) + i) % 1024);
              exp_bn_q.push_back((int'(cmd_n_addr) + i) % 1024);
              exp_bw_q.push_back((int'(cmd_w_addr) + r * int'(cmd_len) + i) % 1024);
            end
          end
        end
      end

      if (nram_rd_en || wram_rd_en) chk("rd_en_pair", nram_rd_en, wram_rd_en);
      if (nram_rd_en) begin
        rd_cnt++;
        n_log.push_back(int'(nram_rd_addr));
        if (exp_n_q.size() == 0) chk("nram_rd_extra", 1, 0);
        else chk("nram_addr", nram_rd_addr, exp_n_q.pop_front());
      end
      if (wram_rd_en) begin
        w_log.push_back(int'(wram_rd_addr));
        if (exp_w_q.size() == 0) chk("wram_rd_extra", 1, 0);
        else chk("wram_addr", wram_rd_addr, exp_w_q.pop_front());
      end

      if (mpe_neuron_valid || mpe_weight_valid)
        chk("valid_pair", mpe_neuron_valid, mpe_weight_valid);
      if (prev_stall) begin
        chk("stall_hold_valid", mpe_neuron_valid, 1);
        chk("stall_hold_neuron", mpe_neuron, prev_n);
        chk("stall_hold_weight", mpe_weight, prev_w);
      end
      acc = mpe_neuron_valid && mpe_weight_valid && mpe_neuron_ready && mpe_weight_ready;
      if (acc) begin
        acc_log.push_back(cyc);
        if (exp_bn_q.size() == 0) chk("beat_extra", 1, 0);
        else begin
          a = exp_bn_q.pop_front();
          chk("neuron_data", mpe_neuron, nword(a));
          a = exp_bw_q.pop_front();
          chk("weight_data", mpe_weight, wword(a));
        end
        rsp_pend--;
        if (rsp_pend == 0) rsp_delay = 3;
      end
      prev_stall = mpe_neuron_valid && !acc;
      prev_n = mpe_neuron;
      prev_w = mpe_weight;

      if (prev_uop_hs) chk("uop_valid_drop", mpe_uop_valid, 0);
      prev_uop_hs = 0;
      if (mpe_uop_valid && mpe_uop_ready) begin
        uop_cnt++;
        prev_uop_hs = 1;
        chk("uop_before_result", rsp_outstanding, 0);
        if (exp_uop_q.size() == 0) chk("uop_extra", 1, 0);
        else chk("uop_value", mpe_uop, exp_uop_q.pop_front());
        rsp_pend = int'(mpe_uop);
        rsp_outstanding = 1;
      end

      if (res_valid) begin
        idx_log.push_back(int'(res_idx));
        if (exp_idx_q.size() == 0) chk("res_extra", 1, 0);
        else begin
          ei = exp_idx_q.pop_front();
          chk("res_idx", res_idx, ei);
          if (exp_rdata_q.size() == 0) chk("res_data_extra", 1, 0);
          else chk("res_data", res_data, exp_rdata_q.pop_front());
          if (ei == job_rep - 1) exp_done = 1;
        end
      end
      if (done || exp_done) chk("done", done, exp_done);
      if (done) done_cyc = cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic clear_logs();
    n_log.delete(); w_log.delete(); acc_log.delete(); idx_log.delete();
    uop_cnt = 0; rd_cnt = 0;
  endtask

  task automatic start_job(input int n, input int w, input int len, input int rep);
    bit seen;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_n_addr = AW'(n); cmd_w_addr = AW'(w);
    cmd_len = 8'(len); cmd_rep = 8'(rep);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin seen = 1; break; end
    end
    chk("cmd_accepted", seen, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("job_done_seen", got, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_uop_valid"}, mpe_uop_valid, 0);
    chk({tag, "_uop"}, mpe_uop, 0);
    chk({tag, "_nvalid"}, mpe_neuron_valid, 0);
    chk({tag, "_wvalid"}, mpe_weight_valid, 0);
    chk({tag, "_rd_en"}, {nram_rd_en, wram_rd_en}, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_perf"}, {perf_busy, perf_stall}, 0);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_n_addr = '0; cmd_w_addr = '0; cmd_len = '0; cmd_rep = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Test 1: len=4 rep=1
    clear_logs();
    start_job(32'h10, 32'h20, 4, 1);
    wait_done();
    chk("t1_uop_cnt", uop_cnt, 1);
    chk("t1_rd_cnt", rd_cnt, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_nram_addr", n_log[k], 32'h10 + k);
      chk("t1_wram_addr", w_log[k], 32'h20 + k);
    end
    chk("t1_beats", acc_log.size(), 4);
    chk("t1_back_to_back", acc_log[3] - acc_log[0], 3);
    chk("t1_res_cnt", idx_log.size(), 1);
    chk("t1_res_idx", idx_log[0], 0);
`ifdef MPE_DISPATCH_PERF_EN
    chk("t1_perf_busy_nonzero", perf_busy != 0, 1);
`else
    chk("t1_perf_tied", {perf_busy, perf_stall}, 0);
`endif

    // Test 2: len=3 rep=3 w=0x100
    clear_logs();
    start_job(0, 32'h100, 3, 3);
    wait_done();
    chk("t2_uop_cnt", uop_cnt, 3);
    chk("t2_rd_cnt", rd_cnt, 9);
    for (int k = 0; k < 9; k++) begin
      chk("t2_wram_addr", w_log[k], 32'h100 + k);
      chk("t2_nram_addr", n_log[k], k % 3);
    end
    for (int k = 0; k < 3; k++) chk("t2_res_idx", idx_log[k], k);

    // Test 3: random backpressure plus a stray PE result while streaming
    clear_logs();
    bp_mode = 1; spur_req = 1;
    start_job(32'h40, 32'h80, 5, 2);
    wait_done();
    bp_mode = 0;
    chk("t3_beats", acc_log.size(), 10);
    chk("t3_res_cnt", idx_log.size(), 2);
    chk("t3_stray_consumed", spur_req, 0);

    // Test 4: len=0 rep=5
    clear_logs();
    start_job(32'h10, 32'h20, 0, 5);
    wait_done();
    chk("t4_done_latency", done_cyc - hs_cyc, 1);
    chk("t4_uop_cnt", uop_cnt, 0);
    chk("t4_rd_cnt", rd_cnt, 0);

    // Test 5: reset during beat 2 of 4, then a normal len=2 job
    clear_logs();
    start_job(32'h200, 32'h300, 4, 1);
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (acc_log.size() >= 2) begin hit = 1; break; end
    end
    chk("t5_reached_beat2", hit, 1);
    #2;
    rst_n = 1'b0;
    exp_n_q.delete(); exp_w_q.delete(); exp_bn_q.delete(); exp_bw_q.delete();
    exp_uop_q.delete(); exp_idx_q.delete(); exp_rdata_q.delete();
    rsp_pend = 0; rsp_delay = 0; rsp_outstanding = 0;
    zero_due = 0; prev_stall = 0; prev_uop_hs = 0;
    #1;
    chk_reset_outputs("t5_async");
    repeat (2) @(negedge clk);
    chk_reset_outputs("t5_held");
    rst_n = 1'b1;
    clear_logs();
    start_job(32'h30, 32'h50, 2, 1);
    wait_done();
    chk("t5_res_cnt", idx_log.size(), 1);
    chk("t5_beats", acc_log.size(), 2);

    // Test 6: neuron and weight address wrap
    clear_logs();
    start_job(32'h3FF, 32'h3FF, 2, 1);
    wait_done();
    chk("t6_nram_addr0", n_log[0], 32'h3FF);
    chk("t6_nram_addr1", n_log[1], 32'h000);
    chk("t6_wram_addr1", w_log[1], 32'h000);

    chk("left_reads", exp_n_q.size(), 0);
    chk("left_beats", exp_bn_q.size(), 0);
    chk("left_results", exp_idx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
